score_lives_keeper: RTL and testbench
=====================================

SCORE_LIVES_KEEPER -- requirements
Module: score_lives_keeper

Interface
REQ-001 SHALL have parameter POINTS_BCD, default 16'h0010, meaning the 4-digit BCD points added per enemy hit.
REQ-002 SHALL have parameter START_LIVES, default 3, meaning the lives loaded at game start (range 1..7).
REQ-003 SHALL have parameter INVULN_FRAMES, default 60, meaning the frames of invulnerability after a player hit (range 1..255).
REQ-004 SHALL have parameter FLASH_FRAMES, default 4, meaning the frames per flash half-period while invulnerable (range 1..15).
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port startOfFrame  input  1  one-clk pulse per video frame.
REQ-008 SHALL have port enemyHitPulse  input  1  one-clk pulse: player shot hit an alien (one per frame max, from game_controller).
REQ-009 SHALL have port playerHitPulse  input  1  one-clk pulse: alien shot/alien hit the player.
REQ-010 SHALL have port startKey  input  1  level key, synchronous to clk; only the rising edge is used.
REQ-011 SHALL have port score_bcd  output  16  4 BCD digits; [15:12] is the most significant digit.
REQ-012 SHALL have port lives  output  3  remaining lives, binary.
REQ-013 SHALL have port playing  output  1  high in PLAYING or INVULN.
REQ-014 SHALL have port invulnerable  output  1  high in INVULN.
REQ-015 SHALL have port flash  output  1  player sprite blank request (1 = hide the player).
REQ-016 SHALL have port game_over  output  1  high in GAME_OVER.

Function
REQ-017 SHALL implement FSM states IDLE, PLAYING, INVULN, GAME_OVER; all outputs registered.
REQ-018 SHALL detect a startKey rising edge as startKey=1 with the previous-cycle startKey=0; held key SHALL produce one edge.
REQ-019 IDLE or GAME_OVER + startKey edge -> PLAYING next cycle, with score_bcd=0 and lives=START_LIVES loaded in the same cycle.
REQ-020 startKey edges in PLAYING/INVULN SHALL be ignored.
REQ-021 In PLAYING or INVULN, enemyHitPulse SHALL set score_bcd to score_bcd+POINTS_BCD on the next clk edge (latency 1), as a digit-wise BCD add with carry.
REQ-022 Score SHALL saturate at 16'h9999 (a carry out of the top digit forces 9999); no wrap to 0.
REQ-023 In IDLE/GAME_OVER, enemyHitPulse SHALL be ignored and score held (GAME_OVER shows the final score).
REQ-024 PLAYING + playerHitPulse with lives>1 -> INVULN, lives-1, invuln counter=INVULN_FRAMES, flash phase counter=FLASH_FRAMES, flash=1.
REQ-025 PLAYING + playerHitPulse with lives==1 -> GAME_OVER, lives=0, flash=0.
REQ-026 INVULN SHALL ignore playerHitPulse (lives unchanged).
REQ-027 INVULN: each startOfFrame SHALL decrement the invuln counter; a startOfFrame with counter==1 -> PLAYING, flash=0.
REQ-028 INVULN: each startOfFrame SHALL decrement the flash phase counter; on reaching 0 it SHALL toggle flash and reload FLASH_FRAMES.
REQ-029 enemyHitPulse and playerHitPulse in the same cycle SHALL both be applied (score add and life loss together, including the final-life case).
REQ-030 startOfFrame coinciding with a hit pulse SHALL be processed in the same cycle with no event lost.
REQ-031 playing, invulnerable, and game_over SHALL be mutually consistent with the state at all times (never two of invulnerable/game_over high).

Reset
REQ-032 resetN=0 SHALL asynchronously force: state=IDLE, score_bcd=0, lives=START_LIVES, playing=0, invulnerable=0, flash=0, game_over=0, counters=0, edge-detect register=0.
REQ-033 Reset mid-game (any state) SHALL discard all progress; after release, no edge SHALL be detected until startKey is seen low then high.

Verification
REQ-034 Reset, startKey 0->1 -> playing=1 next cycle, score_bcd=0000, lives=3; key held 10 cycles -> no further effect.
REQ-035 In PLAYING, 13 enemyHitPulses -> score_bcd=16'h0130; preload 9990 then 2 hits -> 9999 (saturated).
REQ-036 In PLAYING, playerHitPulse -> lives=2, invulnerable=1, flash=1; flash toggles every 4 frames; a second playerHitPulse at frame 10 -> lives stays 2; at frame 60 -> PLAYING, flash=0.
REQ-037 lives=1, enemyHitPulse and playerHitPulse in the same cycle -> score +10, lives=0, game_over=1; later enemy hits leave the score unchanged.
REQ-038 In GAME_OVER, startKey edge -> PLAYING, score 0000, lives 3; resetN pulse during INVULN -> IDLE, all outputs at reset values.

Source files
------------

// File: rtl/score_lives_keeper.sv
// -----------------------------------------------------------------------------
// score_lives_keeper
//
// Keeps the player score (4-digit BCD, saturating at 9999), the remaining
// lives and the invulnerability/flash window that follows a player hit.
// A rising edge of startKey starts (or restarts) a game from IDLE or GAME_OVER.
//
// Ports
//   clk            in   system clock
//   resetN         in   asynchronous active-low reset
//   startOfFrame   in   one-clk pulse per video frame
//   enemyHitPulse  in   one-clk pulse, player shot hit an alien
//   playerHitPulse in   one-clk pulse, player was hit
//   startKey       in   level key, synchronous to clk
//   score_bcd      out  [15:0] score, 4 BCD digits, [15:12] most significant
//   lives          out  [2:0]  remaining lives
//   playing        out  high in PLAYING or INVULN
//   invulnerable   out  high in INVULN
//   flash          out  1 = hide the player sprite
//   game_over      out  high in GAME_OVER
//
// FSM states
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_IDLE     | after reset, waiting for a startKey edge
//   S_PLAYING  | game running, player can be hit
//   S_INVULN   | game running, player hits ignored, sprite flashing
//   S_GAME_OVER| last life lost, final score displayed, waiting for startKey
// -----------------------------------------------------------------------------
module score_lives_keeper #(
    parameter logic [15:0] POINTS_BCD    = 16'h0010,
    parameter int          START_LIVES   = 3,
    parameter int          INVULN_FRAMES = 60,
    parameter int          FLASH_FRAMES  = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enemyHitPulse,
    input  logic        playerHitPulse,
    input  logic        startKey,
    output logic [15:0] score_bcd,
    output logic [2:0]  lives,
    output logic        playing,
    output logic        invulnerable,
    output logic        flash,
    output logic        game_over
);

    localparam logic [2:0] LP_START_LIVES = 3'(START_LIVES);
    localparam logic [7:0] LP_INVULN      = 8'(INVULN_FRAMES);
    localparam logic [3:0] LP_FLASH       = 4'(FLASH_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PLAYING   = 2'd1,
        S_INVULN    = 2'd2,
        S_GAME_OVER = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_score;
    logic [2:0]  r_lives;
    logic        r_playing;
    logic        r_invulnerable;
    logic        r_flash;
    logic        r_game_over;
    logic [7:0]  r_invuln_cnt;
    logic [3:0]  r_flash_cnt;
    // Holds "startKey was low last cycle". Resetting it to 0 means a key that
    // is already held when reset releases cannot produce an edge until it has
    // been seen low once.
    logic        r_key_prev_low;

    logic [15:0] w_score_next;
    logic        w_key_edge;

    // Digit-wise BCD add; a carry out of the top digit saturates to 9999.
    function automatic logic [15:0] f_bcd_add_sat(input logic [15:0] a,
                                                  input logic [15:0] b);
        logic [4:0]  s;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = 16'h0000;
        for (int d = 0; d < 4; d++) begin
            s = {1'b0, a[d*4 +: 4]} + {1'b0, b[d*4 +: 4]} + {4'b0000, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[d*4 +: 4] = s[3:0];
        end
        return c ? 16'h9999 : r;
    endfunction

    assign w_score_next = f_bcd_add_sat(r_score, POINTS_BCD);
    assign w_key_edge   = startKey & r_key_prev_low;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= S_IDLE;
            r_score        <= 16'h0000;
            r_lives        <= LP_START_LIVES;
            r_playing      <= 1'b0;
            r_invulnerable <= 1'b0;
            r_flash        <= 1'b0;
            r_game_over    <= 1'b0;
            r_invuln_cnt   <= 8'd0;
            r_flash_cnt    <= 4'd0;
            r_key_prev_low <= 1'b0;
        end else begin
            r_key_prev_low <= ~startKey;

            case (r_state)
                S_IDLE, S_GAME_OVER: begin
                    if (w_key_edge) begin
                        r_state        <= S_PLAYING;
                        r_score        <= 16'h0000;
                        r_lives        <= LP_START_LIVES;
                        r_playing      <= 1'b1;
                        r_invulnerable <= 1'b0;
                        r_flash        <= 1'b0;
                        r_game_over    <= 1'b0;
                        r_invuln_cnt   <= 8'd0;
                        r_flash_cnt    <= 4'd0;
                    end
                end

                S_PLAYING: begin
                    if (enemyHitPulse) begin
                        r_score <= w_score_next;
                    end
                    if (playerHitPulse) begin
                        if (r_lives > 3'd1) begin
                            r_state        <= S_INVULN;
                            r_lives        <= r_lives - 3'd1;
                            r_invulnerable <= 1'b1;
                            r_flash        <= 1'b1;
                            r_invuln_cnt   <= LP_INVULN;
                            r_flash_cnt    <= LP_FLASH;
                        end else begin
                            r_state        <= S_GAME_OVER;
                            r_lives        <= 3'd0;
                            r_playing      <= 1'b0;
                            r_game_over    <= 1'b1;
                            r_flash        <= 1'b0;
                        end
                    end
                end

                S_INVULN: begin
                    // Score keeps counting while invulnerable; player hits are ignored.
                    if (enemyHitPulse) begin
                        r_score <= w_score_next;
                    end
                    if (startOfFrame) begin
                        if (r_invuln_cnt == 8'd1) begin
                            r_state        <= S_PLAYING;
                            r_invulnerable <= 1'b0;
                            r_flash        <= 1'b0;
                            r_invuln_cnt   <= 8'd0;
                            r_flash_cnt    <= 4'd0;
                        end else begin
                            r_invuln_cnt <= r_invuln_cnt - 8'd1;
                            if (r_flash_cnt == 4'd1) begin
                                r_flash     <= ~r_flash;
                                r_flash_cnt <= LP_FLASH;
                            end else begin
                                r_flash_cnt <= r_flash_cnt - 4'd1;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign score_bcd    = r_score;
    assign lives        = r_lives;
    assign playing      = r_playing;
    assign invulnerable = r_invulnerable;
    assign flash        = r_flash;
    assign game_over    = r_game_over;

endmodule

// File: tb/tb_score_lives_keeper.sv
module tb_score_lives_keeper;

    localparam int START = 3;
    localparam int INV   = 60;
    localparam int FL    = 4;
    localparam int PTS   = 10;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        enemyHitPulse = 1'b0;
    logic        playerHitPulse = 1'b0;
    logic        startKey = 1'b0;
    logic [15:0] score_bcd;
    logic [2:0]  lives;
    logic        playing;
    logic        invulnerable;
    logic        flash;
    logic        game_over;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 playing, 2 invulnerable, 3 game over.
    int m_mode, m_score, m_lives, m_elapsed;
    bit m_prev_low;

    score_lives_keeper dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .enemyHitPulse(enemyHitPulse), .playerHitPulse(playerHitPulse),
        .startKey(startKey), .score_bcd(score_bcd), .lives(lives),
        .playing(playing), .invulnerable(invulnerable), .flash(flash),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit exp_flash();
        return (m_mode == 2) && (((m_elapsed / FL) % 2) == 0);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_lives = START; m_elapsed = 0; m_prev_low = 0;
    endtask

    // One clock with the given inputs; the model advances using the same inputs.
    task automatic tick(input bit sof, input bit eh, input bit ph, input bit key);
        bit edge_seen;
        startOfFrame = sof; enemyHitPulse = eh; playerHitPulse = ph; startKey = key;
        @(posedge clk);
        edge_seen = key && m_prev_low;
        m_prev_low = !key;
        if (m_mode == 0 || m_mode == 3) begin
            if (edge_seen) begin
                m_mode = 1; m_score = 0; m_lives = START;
            end
        end else begin
            if (eh) m_score = (m_score + PTS > 9999) ? 9999 : m_score + PTS;
            if (m_mode == 1) begin
                if (ph) begin
                    if (m_lives > 1) begin
                        m_lives--; m_mode = 2; m_elapsed = 0;
                    end else begin
                        m_lives = 0; m_mode = 3;
                    end
                end
            end else if (sof) begin
                m_elapsed++;
                if (m_elapsed == INV) m_mode = 1;
            end
        end
        #1;
        startOfFrame = 0; enemyHitPulse = 0; playerHitPulse = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetN = 0;
        #1;
        model_reset();
    endtask

    task automatic start_game();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (score_bcd !== 16'h0000) begin failures++; $display("FAIL reset_score got=%h exp=0000", score_bcd); end
        checks++; if (lives !== 3'(START)) begin failures++; $display("FAIL reset_lives got=%0d exp=%0d", lives, START); end
        checks++; if ({playing, invulnerable, flash, game_over} !== 4'b0000) begin failures++;
            $display("FAIL reset_flags got=%b exp=0000", {playing, invulnerable, flash, game_over}); end
        @(negedge clk);
        resetN = 1;
    endtask

    task automatic test_start();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL start_playing got=%b exp=1", playing); end
        checks++; if (score_bcd !== 16'h0000) begin failures++; $display("FAIL start_score got=%h exp=0000", score_bcd); end
        checks++; if (lives !== 3'd3) begin failures++; $display("FAIL start_lives got=%0d exp=3", lives); end
        // Held key, with a hit in the middle: a re-start would wipe the score.
        for (int i = 0; i < 10; i++) tick(0, i == 2, 0, 1);
        checks++; if (score_bcd !== 16'h0010 || playing !== 1'b1 || game_over !== 1'b0) begin failures++;
            $display("FAIL start_held got=%h/%b exp=0010/1", score_bcd, playing); end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_score();
        apply_reset(); @(negedge clk); resetN = 1;
        start_game();
        for (int i = 0; i < 13; i++) tick(i % 3 == 0, 1, 0, 0);
        checks++; if (score_bcd !== 16'h0130) begin failures++; $display("FAIL score_13 got=%h exp=0130", score_bcd); end
        for (int i = 0; i < 986; i++) tick(0, 1, 0, 0);
        checks++; if (score_bcd !== 16'h9990) begin failures++; $display("FAIL score_9990 got=%h exp=9990", score_bcd); end
        tick(0, 1, 0, 0);
        checks++; if (score_bcd !== 16'h9999) begin failures++; $display("FAIL score_sat1 got=%h exp=9999", score_bcd); end
        tick(0, 1, 0, 0);
        checks++; if (score_bcd !== 16'h9999) begin failures++; $display("FAIL score_sat2 got=%h exp=9999", score_bcd); end
    endtask

    task automatic test_invuln();
        apply_reset(); @(negedge clk); resetN = 1;
        start_game();
        tick(0, 0, 1, 0);
        checks++; if (lives !== 3'd2 || invulnerable !== 1'b1 || flash !== 1'b1) begin failures++;
            $display("FAIL inv_enter got=%0d/%b/%b exp=2/1/1", lives, invulnerable, flash); end
        for (int f = 1; f <= 60; f++) begin
            tick(1, 0, f == 10, 0);
            tick(0, 0, 0, 0);
            checks++; if (flash !== exp_flash()) begin failures++;
                $display("FAIL inv_flash frame=%0d got=%b exp=%b", f, flash, exp_flash()); end
            if (f == 4) begin
                checks++; if (flash !== 1'b0) begin failures++; $display("FAIL inv_flash4 got=%b exp=0", flash); end
            end
            if (f == 10) begin
                checks++; if (lives !== 3'd2) begin failures++; $display("FAIL inv_ignore_hit got=%0d exp=2", lives); end
            end
            if (f == 59) begin
                checks++; if (invulnerable !== 1'b1) begin failures++; $display("FAIL inv_59 got=%b exp=1", invulnerable); end
            end
        end
        checks++; if (playing !== 1'b1 || invulnerable !== 1'b0 || flash !== 1'b0) begin failures++;
            $display("FAIL inv_exit got=%b/%b/%b exp=1/0/0", playing, invulnerable, flash); end
    endtask

    task automatic test_final_life();
        // Entry: playing with 2 lives from test_invuln.
        tick(0, 0, 1, 0);
        for (int f = 0; f < INV; f++) tick(1, 0, 0, 0);
        checks++; if (lives !== 3'd1 || playing !== 1'b1 || invulnerable !== 1'b0) begin failures++;
            $display("FAIL last_life got=%0d/%b exp=1/1", lives, playing); end
        tick(0, 0, 0, 0);
        tick(0, 1, 1, 0);
        checks++; if (score_bcd !== to_bcd(m_score) || m_score != PTS) begin failures++;
            $display("FAIL final_score got=%h exp=%h", score_bcd, to_bcd(m_score)); end
        checks++; if (lives !== 3'd0 || game_over !== 1'b1 || playing !== 1'b0 || invulnerable !== 1'b0 || flash !== 1'b0) begin
            failures++; $display("FAIL final_gameover got=%0d/%b/%b exp=0/1/0", lives, game_over, playing); end
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 0);
        checks++; if (score_bcd !== 16'h0010) begin failures++; $display("FAIL over_hold got=%h exp=0010", score_bcd); end
    endtask

    task automatic test_restart_and_reset();
        tick(0, 0, 0, 1);
        checks++; if (playing !== 1'b1 || game_over !== 1'b0 || score_bcd !== 16'h0000 || lives !== 3'd3) begin failures++;
            $display("FAIL restart got=%b/%b/%h/%0d exp=1/0/0000/3", playing, game_over, score_bcd, lives); end
        tick(0, 1, 1, 1);
        checks++; if (invulnerable !== 1'b1) begin failures++; $display("FAIL pre_reset_inv got=%b exp=1", invulnerable); end
        #2 resetN = 0;
        #1;
        model_reset();
        checks++; if (score_bcd !== 16'h0000 || lives !== 3'd3 || {playing, invulnerable, flash, game_over} !== 4'b0000) begin
            failures++; $display("FAIL async_reset got=%h/%0d/%b exp=0000/3/0000", score_bcd, lives,
                {playing, invulnerable, flash, game_over}); end
        @(negedge clk); resetN = 1;
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL held_after_reset got=%b exp=0", playing); end
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL start_after_reset got=%b exp=1", playing); end
    endtask

    task automatic test_random();
        bit key;
        key = startKey;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) key = !key;
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0, key);
            checks++;
            if (score_bcd !== to_bcd(m_score) || lives !== 3'(m_lives) ||
                playing !== (m_mode == 1 || m_mode == 2) || invulnerable !== (m_mode == 2) ||
                game_over !== (m_mode == 3) || flash !== exp_flash()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h/%0d/%b%b%b%b exp=%h/%0d/%b%b%b%b", i, score_bcd, lives,
                    playing, invulnerable, game_over, flash, to_bcd(m_score), m_lives,
                    m_mode == 1 || m_mode == 2, m_mode == 2, m_mode == 3, exp_flash());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_score();
        test_invuln();
        test_final_life();
        test_restart_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
